// File: rtl/conv_window_mac.sv
// Convolution MAC: accepts one KxK window per cycle and emits one output pixel per window,
// through a product stage, a padded binary adder tree, a bias stage and a ReLU/shift/saturate register.
//
// state  | meaning
// IDLE   | no frame in progress, windows are dropped
// ACTIVE | accepting windows of the current frame
// DRAIN  | every window of the frame accepted, waiting for the last output

module conv_window_mac #(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int KERNEL_SIZE  = 3,
    parameter int ACC_WIDTH    = 32,
    parameter int IMG_WIDTH    = 6,
    parameter int IMG_HEIGHT   = 6,
    parameter int SHIFT        = 0
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              frame_start,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]     window_in,
    input  logic                                              window_valid,
    input  logic                                              weight_we,
    input  logic [$clog2(KERNEL_SIZE*KERNEL_SIZE)-1:0]        weight_addr,
    input  logic signed [WEIGHT_WIDTH-1:0]                    weight_data,
    input  logic signed [ACC_WIDTH-1:0]                       bias,
    output logic signed [ACC_WIDTH-1:0]                       acc_out,
    output logic [DATA_WIDTH-1:0]                             pixel_out,
    output logic                                              out_valid,
    output logic [$clog2(IMG_WIDTH)-1:0]                      out_x,
    output logic [$clog2(IMG_HEIGHT)-1:0]                     out_y,
    output logic                                              frame_done,
    output logic                                              busy
);

    localparam int TAPS   = KERNEL_SIZE * KERNEL_SIZE;
    localparam int ADDR_W = $clog2(TAPS);
    localparam int LEVELS = $clog2(TAPS);
    localparam int LAT    = LEVELS + 2;
    localparam int LEAVES = 1 << LEVELS;
    localparam int PROD_W = DATA_WIDTH + WEIGHT_WIDTH + 1;
    localparam int TOTAL  = IMG_WIDTH * IMG_HEIGHT;
    localparam int CNT_W  = $clog2(TOTAL);
    localparam int X_W    = $clog2(IMG_WIDTH);
    localparam int Y_W    = $clog2(IMG_HEIGHT);

    localparam logic [CNT_W-1:0]            LAST_IN = CNT_W'(TOTAL - 1);
    localparam logic [X_W-1:0]              LAST_X  = X_W'(IMG_WIDTH - 1);
    localparam logic [Y_W-1:0]              LAST_Y  = Y_W'(IMG_HEIGHT - 1);
    localparam logic signed [ACC_WIDTH-1:0] PIX_MAX = ACC_WIDTH'((1 << DATA_WIDTH) - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t                         state;
    state_t                         state_nxt;
    logic                           accept;
    logic                           last_in;
    logic [CNT_W-1:0]               in_cnt;
    logic [CNT_W-1:0]               in_idx;
    logic signed [WEIGHT_WIDTH-1:0] weight [TAPS];
    logic signed [PROD_W-1:0]       prod [LEAVES];
    logic signed [ACC_WIDTH-1:0]    tree [LEVELS+1][LEAVES];
    logic [LAT-1:0]                 vld;
    logic signed [ACC_WIDTH-1:0]    acc_s;

    function automatic logic [DATA_WIDTH-1:0] relu_sat(input logic signed [ACC_WIDTH-1:0] a);
        logic signed [ACC_WIDTH-1:0] s;
        s = a >>> SHIFT;
        if (a[ACC_WIDTH-1])
            relu_sat = '0;
        else if (s > PIX_MAX)
            relu_sat = '1;
        else
            relu_sat = s[DATA_WIDTH-1:0];
    endfunction

    // frame_start counts as an open frame so its own window is the first of the new frame
    assign accept     = window_valid && (state == ACTIVE || frame_start);
    assign in_idx     = frame_start ? '0 : in_cnt;
    assign last_in    = accept && (in_idx == LAST_IN);
    assign frame_done = out_valid && (out_x == LAST_X) && (out_y == LAST_Y);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (frame_start) begin
            state_nxt = last_in ? DRAIN : ACTIVE;
        end else begin
            case (state)
                ACTIVE:  if (last_in)    state_nxt = DRAIN;
                DRAIN:   if (frame_done) state_nxt = IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            in_cnt <= '0;
        else if (accept)
            in_cnt <= last_in ? '0 : in_idx + 1'b1;
        else if (frame_start)
            in_cnt <= '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++)
                weight[k] <= '0;
        end else if (weight_we && ({1'b0, weight_addr} < (ADDR_W+1)'(TAPS))) begin
            weight[weight_addr] <= weight_data;
        end
    end

    // Tree is padded to a power of two; the padding leaves stay zero and fold away
    always_comb begin
        for (int k = 0; k < LEAVES; k++)
            prod[k] = '0;
        for (int k = 0; k < TAPS; k++)
            prod[k] = PROD_W'($signed({1'b0, window_in[(TAPS-k)*DATA_WIDTH-1 -: DATA_WIDTH]}))
                    * PROD_W'(weight[k]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l <= LEVELS; l++)
                for (int i = 0; i < LEAVES; i++)
                    tree[l][i] <= '0;
            vld   <= '0;
            acc_s <= '0;
        end else begin
            vld <= frame_start ? LAT'(accept) : {vld[LAT-2:0], accept};
            if (accept)
                for (int i = 0; i < LEAVES; i++)
                    tree[0][i] <= ACC_WIDTH'(prod[i]);
            for (int l = 1; l <= LEVELS; l++)
                if (vld[l-1])
                    for (int i = 0; i < (LEAVES >> l); i++)
                        tree[l][i] <= tree[l-1][2*i] + tree[l-1][2*i+1];
            if (vld[LEVELS])
                acc_s <= tree[LEVELS][0] + bias;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_out   <= '0;
            pixel_out <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= vld[LAT-1] && !frame_start;
            if (vld[LAT-1] && !frame_start) begin
                acc_out   <= acc_s;
                pixel_out <= relu_sat(acc_s);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_x <= '0;
            out_y <= '0;
        end else if (frame_start) begin
            out_x <= '0;
            out_y <= '0;
        end else if (out_valid) begin
            if (out_x == LAST_X) begin
                out_x <= '0;
                out_y <= (out_y == LAST_Y) ? '0 : out_y + 1'b1;
            end else begin
                out_x <= out_x + 1'b1;
            end
        end
    end

endmodule
